red_serial: RTL and testbench
=============================

RED_SERIAL -- requirements
Module: red_serial

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port A, input, 16 bits: operand A, sampled only on input handshake.
REQ-004 SHALL have port B, input, 16 bits: operand B, sampled only on input handshake.
REQ-005 SHALL have port in_valid, input, 1 bit: A/B valid this cycle.
REQ-006 SHALL have port in_ready, output, 1 bit: block can accept operands.
REQ-007 SHALL have port out_valid, output, 1 bit: Sum valid.
REQ-008 SHALL have port out_ready, input, 1 bit: consumer takes Sum this cycle.
REQ-009 SHALL have port Sum, output, 16 bits: reduction result.
REQ-010 SHALL have port busy, output, 1 bit: high in CALC and DONE.

Function
REQ-011 SHALL compute total = A[7:0] + B[7:0] + A[15:8] + B[15:8] as a 10-bit unsigned value; byte operands are unsigned, and 10 bits holds the maximum of 1020 without overflow.
REQ-012 SHALL set Sum = {6 copies of total[9], total[9:0]}.
REQ-013 SHALL implement states IDLE, CALC and DONE; reset enters IDLE.
REQ-014 In IDLE, in_ready SHALL be 1; in CALC and DONE it SHALL be 0.
REQ-015 On an input handshake (in_valid and in_ready at an edge), the block SHALL capture A and B, clear the 10-bit accumulator, set step = 0 and enter CALC.
REQ-016 In CALC, at each edge the block SHALL add one byte to the accumulator, in order: step 0 adds A[7:0], step 1 adds B[7:0], step 2 adds A[15:8], step 3 adds B[15:8].
REQ-017 Each step SHALL use one 8-bit add whose carry-out increments accumulator bits [9:8].
REQ-018 After step 3 the block SHALL enter DONE; out_valid SHALL rise exactly 4 edges after the acceptance edge.
REQ-019 In DONE, out_valid SHALL be 1, and Sum SHALL be stable until the output handshake.
REQ-020 On an output handshake (out_valid and out_ready at an edge), the block SHALL return to IDLE; in_ready SHALL be 1 in the next cycle, with no overlap.
REQ-021 Changes on A and B outside the acceptance edge SHALL NOT affect the result.
REQ-022 Outside DONE, out_valid SHALL be 0 and Sum SHALL hold its last value, or 0 if no result has been produced since reset.
REQ-023 The step counter SHALL be 2 bits, and CALC SHALL exit on step == 3; wrap-around of the counter SHALL NOT start a further add.
REQ-024 in_valid asserted in CALC or DONE SHALL be ignored, with no capture and no queueing.

Reset
REQ-025 When rst = 1 at an edge, the block SHALL set state = IDLE, step = 0, accumulator = 0, captured operands = 0 and Sum register = 0.
REQ-026 After reset, outputs SHALL be out_valid = 0, busy = 0, in_ready = 1 and Sum = 0x0000.
REQ-027 Reset SHALL take priority over every handshake; reset in CALC or DONE SHALL discard the in-flight result.

Structure
REQ-028 A shared package SHALL hold the state enumeration (IDLE, CALC, DONE), the step-count constant 4 and the result width constants (10, 16).
REQ-029 The byte adder SHALL be one sub-module, add8: two chained CLA4 stages with inputs a[7:0], b[7:0], cin and outputs s[7:0], cout.
REQ-030 The block SHALL use no other sub-modules; the FSM, counter and accumulator SHALL be in red_serial.

Verification
REQ-031 The bench SHALL check A=0x0102, B=0x0304 -> Sum=0x000A, with out_valid rising exactly 4 edges after acceptance.
REQ-032 The bench SHALL check A=0xFFFF, B=0xFFFF -> total 0x3FC -> Sum=0xFFFC.
REQ-033 The bench SHALL check A=0x8080, B=0x8080 -> total 0x200 -> Sum=0xFE00; and A=0x7F7F, B=0x0101 -> Sum=0x0100.
REQ-034 With out_ready held 0 for 10 cycles in DONE, the bench SHALL check that out_valid stays 1, Sum stays stable, in_ready stays 0, and in_valid pulses in that window are ignored.
REQ-035 The bench SHALL assert rst at step 2 of CALC and check that the next cycle shows IDLE with out_valid=0 and Sum=0x0000, then that a new transaction A=0x0001, B=0x0001 gives Sum=0x0002.
REQ-036 The bench SHALL run back-to-back transactions with out_ready=1 and in_valid=1 and check a throughput of one result per 6 cycles, with A/B changed after acceptance having no effect.

Source files
------------

// File: rtl/red_serial_pkg.sv
// red_serial_pkg: shared states and widths for the serial byte-sum reducer
package red_serial_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
  localparam int STEPS = 4;
  localparam int TOT_W = 10;
  localparam int SUM_W = 16;
endpackage

// File: rtl/red_serial_add8.sv
// add8: 8-bit adder built from two chained 4-bit carry-lookahead stages
module add8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] s,
  output logic       cout
);
  function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic ci);
    logic [3:0] p, g;
    logic [4:0] c;
    p = x ^ y;
    g = x & y;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    return {c[4], p ^ c[3:0]};
  endfunction
  logic [4:0] lo, hi;
  assign lo   = cla4(a[3:0], b[3:0], cin);
  assign hi   = cla4(a[7:4], b[7:4], lo[4]);
  assign s    = {hi[3:0], lo[3:0]};
  assign cout = hi[4];
endmodule

// File: rtl/red_serial.sv
// red_serial: sums the four bytes of A and B one byte per cycle, sign-extends the 10-bit total
module red_serial import red_serial_pkg::*; (
  input  logic             clk,
  input  logic             rst,
  input  logic [SUM_W-1:0] A,
  input  logic [SUM_W-1:0] B,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] Sum,
  output logic             busy
);
  localparam logic [1:0] STEP_LAST = 2'(STEPS - 1);
  state_e           state_q;
  logic [1:0]       step_q;
  logic [TOT_W-1:0] acc_q, acc_d;
  logic [SUM_W-1:0] a_q, b_q, sum_q;
  logic [7:0]       byte_sel, add_s;
  logic             add_c;
  always_comb begin
    byte_sel = step_q == 2'd0 ? a_q[7:0] :
               step_q == 2'd1 ? b_q[7:0] :
               step_q == 2'd2 ? a_q[15:8] : b_q[15:8];
    acc_d    = {acc_q[9:8] + {1'b0, add_c}, add_s};
  end
  add8 u_add8 (.a(acc_q[7:0]), .b(byte_sel), .cin(1'b0), .s(add_s), .cout(add_c));
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          a_q     <= A;
          b_q     <= B;
          acc_q   <= '0;
          step_q  <= '0;
          state_q <= CALC;
        end
        CALC: begin
          acc_q  <= acc_d;
          step_q <= step_q + 2'd1;
          if (step_q == STEP_LAST) begin
            state_q <= DONE;
            sum_q   <= {{(SUM_W-TOT_W){acc_d[TOT_W-1]}}, acc_d};
          end
        end
        DONE: if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy      = state_q != IDLE;
  assign Sum       = sum_q;
endmodule

// File: tb/tb_red_serial.sv
// tb_red_serial: directed vectors with hand-computed sums for red_serial
module tb_red_serial;
  logic        clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic [15:0] A = 0, B = 0;
  logic        in_ready, out_valid, busy;
  logic [15:0] Sum;
  int          n_run = 0, n_fail = 0, cyc = 0;

  red_serial dut (.clk(clk), .rst(rst), .A(A), .B(B), .in_valid(in_valid), .in_ready(in_ready),
                  .out_valid(out_valid), .out_ready(out_ready), .Sum(Sum), .busy(busy));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      tick;
      n++;
    end
  endtask

  task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp, input string tag);
    int n;
    check({tag, "_in_ready"}, in_ready, 1);
    A = a; B = b; in_valid = 1;
    tick;
    in_valid = 0; A = ~a; B = 16'($urandom);
    check({tag, "_busy"}, busy, 1);
    check({tag, "_in_ready_calc"}, in_ready, 0);
    wait_valid(n);
    check({tag, "_latency"}, n, 4);
    check({tag, "_sum"}, Sum, exp);
  endtask

  task automatic run(input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp, input string tag);
    launch(a, b, exp, tag);
    out_ready = 1;
    tick;
    out_ready = 0;
    check({tag, "_idle_ready"}, in_ready, 1);
    check({tag, "_idle_valid"}, out_valid, 0);
    check({tag, "_sum_hold"}, Sum, exp);
  endtask

  logic [15:0] va [3] = '{16'h0102, 16'hFFFF, 16'h7F7F};
  logic [15:0] vb [3] = '{16'h0304, 16'hFFFF, 16'h0101};
  logic [15:0] ve [3] = '{16'h000A, 16'hFFFC, 16'h0100};

  initial begin
    int n, m, prev;
    repeat (2) tick;
    rst = 0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sum", Sum, 16'h0000);

    run(16'h0102, 16'h0304, 16'h000A, "basic");
    run(16'hFFFF, 16'hFFFF, 16'hFFFC, "max");
    run(16'h8080, 16'h8080, 16'hFE00, "b9");
    run(16'h7F7F, 16'h0101, 16'h0100, "carry");

    launch(16'hFFFF, 16'hFFFF, 16'hFFFC, "stall");
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0]; A = 16'($urandom); B = 16'($urandom);
      tick;
      check("stall_valid", out_valid, 1);
      check("stall_sum", Sum, 16'hFFFC);
      check("stall_in_ready", in_ready, 0);
    end
    in_valid = 0; out_ready = 1;
    tick;
    out_ready = 0;
    check("stall_release", in_ready, 1);
    tick;
    check("stall_no_queue", busy, 0);

    check("mid_in_ready", in_ready, 1);
    A = 16'h1111; B = 16'h2222; in_valid = 1;
    tick;
    in_valid = 0;
    tick;
    tick;
    check("mid_busy", busy, 1);
    rst = 1;
    tick;
    rst = 0;
    check("mid_rst_ready", in_ready, 1);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_sum", Sum, 16'h0000);
    run(16'h0001, 16'h0001, 16'h0002, "post_rst");

    in_valid = 1; out_ready = 1; prev = 0;
    for (int k = 0; k < 3; k++) begin
      m = 0;
      while (!in_ready && m < 20) begin
        tick;
        m++;
      end
      check("tp_wait", m < 20, 1);
      A = va[k]; B = vb[k];
      tick;
      A = 16'($urandom); B = 16'($urandom);
      wait_valid(n);
      check("tp_latency", n, 4);
      check("tp_sum", Sum, ve[k]);
      if (k > 0) check("tp_gap", cyc - prev, 6);
      prev = cyc;
    end
    in_valid = 0;
    tick;
    out_ready = 0;
    check("tp_end_ready", in_ready, 1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
